// File: rtl/fg_pkg.sv
//==============================================================================
// fg_pkg : shared ROM geometry, channel enum and read-tag type
// Rev 1.0
//==============================================================================
`default_nettype none

package fg_pkg;

  localparam int ROM_AW = 11;
  localparam int ROM_DW = 48;
  localparam int NCH    = 2;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef struct packed {
    logic valid;
    ch_e  ch;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, ch: CH0};

  function automatic logic [NCH-1:0] ch_onehot(input ch_e ch);
    return (ch == CH1) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_tag_pipe.sv
//==============================================================================
// lut_tag_pipe : DEPTH-stage shift register of read tags, async reset to invalid
// Rev 1.0
//==============================================================================
`default_nettype none

module lut_tag_pipe
  import fg_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_d [DEPTH];
  tag_t stage_q [DEPTH];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/lut_rom_arbiter.sv
//==============================================================================
// lut_rom_arbiter : round-robin sharing of the sin/cos2 coefficient ROM between
// two DDS channels. Optional stall counter: LUT_ARB_STALL_CNT_EN. Rev 1.0
//==============================================================================
`default_nettype none

module lut_rom_arbiter
  import fg_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic [NCH-1:0]    req_i,
  input  logic [ROM_AW-1:0] addr0_i,
  input  logic [ROM_AW-1:0] addr1_i,
  output logic [NCH-1:0]    gnt_o,
  output logic [ROM_AW-1:0] rom_ad_o,
  input  logic [ROM_DW-1:0] rom_dout_i,
  output logic [NCH-1:0]    rsp_vld_o,
  output logic [ROM_DW-1:0] rsp_data_o
`ifdef LUT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("lut_rom_arbiter: RD_LAT must be 1..4");
    end
  endgenerate

  logic              last_d, last_q;
  logic [ROM_AW-1:0] rom_ad_d, rom_ad_q;
  logic [NCH-1:0]    rsp_vld_d, rsp_vld_q;
  logic [ROM_DW-1:0] rsp_data_d, rsp_data_q;
  logic              hs;
  ch_e               hs_ch;
  tag_t              tag_in, tag_out;

  // last_q = 1 means ch1 was served last, so ch0 wins the next contention
  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  assign hs    = |(req_i & gnt_o);
  assign hs_ch = ch_e'(gnt_o[1]);

  always_comb begin
    last_d   = last_q;
    rom_ad_d = rom_ad_q;
    tag_in   = TAG_NONE;
    if (hs) begin
      last_d   = gnt_o[1];
      rom_ad_d = (hs_ch == CH1) ? addr1_i : addr0_i;
      tag_in   = '{valid: 1'b1, ch: hs_ch};
    end
  end

  lut_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk   (Fg_CLK),
    .rst_n (RESETn),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (tag_out.valid) begin
      rsp_vld_d  = ch_onehot(tag_out.ch);
      rsp_data_d = rom_dout_i;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_q     <= 1'b1;
      rom_ad_q   <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      last_q     <= last_d;
      rom_ad_q   <= rom_ad_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rom_ad_o   = rom_ad_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_data_o = rsp_data_q;

`ifdef LUT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(req_i & ~gnt_o) && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_rom_arbiter.sv
//==============================================================================
// tb_lut_rom_arbiter : directed stimulus with a response scoreboard
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_lut_rom_arbiter;

  logic        clk;
  logic        RESETn;
  logic [1:0]  req_i;
  logic [10:0] addr0_i, addr1_i;
  logic [1:0]  gnt_o;
  logic [10:0] rom_ad_o;
  logic [47:0] rom_dout_i;
  logic [1:0]  rsp_vld_o;
  logic [47:0] rsp_data_o;
`ifdef LUT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  lut_rom_arbiter #(.RD_LAT(2)) dut (
    .Fg_CLK     (clk),
    .RESETn     (RESETn),
    .req_i      (req_i),
    .addr0_i    (addr0_i),
    .addr1_i    (addr1_i),
    .gnt_o      (gnt_o),
    .rom_ad_o   (rom_ad_o),
    .rom_dout_i (rom_dout_i),
    .rsp_vld_o  (rsp_vld_o),
    .rsp_data_o (rsp_data_o)
`ifdef LUT_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] rom_f(input logic [10:0] a);
    logic [20:0] m;
    m = 21'(a) * 21'd12345;
    return {16'hC0DE ^ {5'b0, a}, m, a};
  endfunction

  // ROM with address register plus output register: data two edges after rom_ad
  logic [47:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_f(rom_ad_o);
    rom_p2 <= rom_p1;
  end
  assign rom_dout_i = rom_p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  vld;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (RESETn && rsp_vld_o != 2'b00) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_vld_o), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_vld", 64'(rsp_vld_o), 64'(e.vld));
        check("rsp_data", 64'(rsp_data_o), 64'(e.data));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step(input logic [1:0] req, input logic [10:0] a0, input logic [10:0] a1,
                      input logic [1:0] exp_g);
    exp_t        e;
    logic [10:0] a;
    @(negedge clk);
    req_i   = req;
    addr0_i = a0;
    addr1_i = a1;
    #1;
    check("gnt", 64'(gnt_o), 64'(exp_g));
    @(posedge clk);
    #1;
    if (exp_g != 2'b00) begin
      a = exp_g[1] ? a1 : a0;
      check("rom_ad", 64'(rom_ad_o), 64'(a));
      e.vld  = exp_g;
      e.data = rom_f(a);
      e.cyc  = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 11'h0, 11'h0, 2'b00);
  endtask

  initial begin
    RESETn  = 1'b0;
    req_i   = 2'b00;
    addr0_i = '0;
    addr1_i = '0;
    repeat (3) @(negedge clk);
    check("rst_rom_ad", 64'(rom_ad_o), 64'd0);
    check("rst_rsp_vld", 64'(rsp_vld_o), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rst_gnt", 64'(gnt_o), 64'd0);
`ifdef LUT_ARB_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
`endif
    RESETn = 1'b1;

    // single ch0 read
    step(2'b01, 11'h005, 11'h000, 2'b01);
    idle(4);

    // ch1 alone up to the top address
    for (int i = 0; i < 4; i++) step(2'b10, 11'h000, 11'h7FC + 11'(i), 2'b10);
    idle(4);

    // continuous contention, ch0 first
    for (int i = 0; i < 6; i++) step(2'b11, 11'h100, 11'h200, (i % 2 == 0) ? 2'b01 : 2'b10);
`ifdef LUT_ARB_STALL_CNT_EN
    #1 check("stall_after_contention", 64'(stall_cnt_o), 64'd6);
`endif
    idle(4);

    // ch0 served last, then ch0 withdraws while ch1 holds
    step(2'b01, 11'h0AA, 11'h000, 2'b01);
    step(2'b11, 11'h0BB, 11'h3CC, 2'b10);
    step(2'b10, 11'h0BB, 11'h3CC, 2'b10);
`ifdef LUT_ARB_STALL_CNT_EN
    check("stall_after_drop", 64'(stall_cnt_o), 64'd7);
`endif
    idle(6);

    // reset with reads in flight
    for (int i = 0; i < 4; i++) step(2'b01, 11'h010 + 11'(i), 11'h000, 2'b01);
    req_i = 2'b00;
    @(negedge clk);
    #1;
    RESETn = 1'b0;
    #1;
    check("midrst_rsp_vld", 64'(rsp_vld_o), 64'd0);
    check("midrst_rom_ad", 64'(rom_ad_o), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    idle(6);
    step(2'b11, 11'h020, 11'h030, 2'b01);
`ifdef LUT_ARB_STALL_CNT_EN
    check("stall_after_rst", 64'(stall_cnt_o), 64'd1);
    for (int i = 0; i < 70000; i++)
      step(2'b11, 11'(i), ~11'(i), (i % 2 == 0) ? 2'b10 : 2'b01);
    check("stall_saturated", 64'(stall_cnt_o), 64'hFFFF);
    step(2'b11, 11'h001, 11'h002, 2'b10);
    step(2'b11, 11'h001, 11'h002, 2'b01);
    check("stall_holds", 64'(stall_cnt_o), 64'hFFFF);
`endif
    idle(8);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
